// File: rtl/params_share_pkg.sv
// Shared types, constants and the LFSR step function for the PSINR
// back-pressure responder.
package params_share_pkg;

  typedef enum logic [1:0] {
    ALWAYS   = 2'd0,
    RANDOM   = 2'd1,
    PERIODIC = 2'd2,
    HOLD     = 2'd3
  } bp_mode_e;

  typedef enum logic {
    CH_RUN   = 1'b0,
    CH_FORCE = 1'b1
  } bp_ch_state_e;

  localparam int BP_MODE_W  = 2;
  localparam int BP_FIELD_W = 8;
  localparam int BP_SEED_W  = 32;
  // Full config bus: mode, thresh, on_len, off_len, max_stall, seed.
  localparam int BP_CFG_WIDTH = BP_MODE_W + 4 * BP_FIELD_W + BP_SEED_W;

  // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] BP_LFSR_POLY         = 32'h8020_0003;
  localparam logic [31:0] BP_LFSR_DEFAULT_SEED = 32'hACE1_0001;

  // Latched pattern configuration; the seed goes straight into the LFSR.
  typedef struct packed {
    logic [BP_FIELD_W-1:0] max_stall;
    logic [BP_FIELD_W-1:0] off_len;
    logic [BP_FIELD_W-1:0] on_len;
    logic [BP_FIELD_W-1:0] thresh;
    bp_mode_e              mode;
  } bp_cfg_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? BP_LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/psinr_bp_lfsr.sv
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1) with synchronous seed load and
// enable; a zero seed is replaced by the default to avoid the lock-up state.
module psinr_bp_lfsr
  import params_share_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= BP_LFSR_DEFAULT_SEED;
    end else if (load) begin
      state <= (seed == 32'h0) ? BP_LFSR_DEFAULT_SEED : seed;
    end else if (en) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/psinr_bp_responder.sv
// Sink-side AXI-stream back-pressure responder for the PSINR output channels.
// Define PSINR_BP_STATS_EN to compile in the per-channel beat/stall counters.
module psinr_bp_responder
  import params_share_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [NUM_CH-1:0]       tvalid_i,
  output logic [NUM_CH-1:0]       tready_o,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [1:0]              cfg_mode,
  input  logic [7:0]              cfg_thresh,
  input  logic [7:0]              cfg_on_len,
  input  logic [7:0]              cfg_off_len,
  input  logic [7:0]              cfg_max_stall,
  input  logic [31:0]             cfg_seed,
  output logic [NUM_CH*CNT_W-1:0] beat_cnt_o,
  output logic [NUM_CH*CNT_W-1:0] stall_cnt_o,
  output logic [NUM_CH-1:0]       force_evt_o
);

  logic                    cfg_load;
  logic [BP_CFG_WIDTH-1:0] cfg_bus;
  bp_cfg_t                 cfg_q;
  logic [31:0]             lfsr_q;
  logic [8:0]              phase_q;
  logic [8:0]              on_eff;
  logic [8:0]              period;
  logic                    phase_on;

  assign cfg_bus  = {cfg_seed, cfg_max_stall, cfg_off_len, cfg_on_len, cfg_thresh, cfg_mode};
  assign cfg_load = cfg_valid & cfg_ready;

  // cfg_ready also marks "out of reset", which delays the first tready by a cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cfg_ready <= 1'b0;
      cfg_q     <= '{max_stall: 8'd0, off_len: 8'd0, on_len: 8'd0, thresh: 8'd0, mode: ALWAYS};
    end else begin
      cfg_ready <= 1'b1;
      if (cfg_load) begin
        cfg_q <= bp_cfg_t'(cfg_bus[BP_CFG_WIDTH-BP_SEED_W-1:0]);
      end
    end
  end

  // Shared PERIODIC phase: on_eff ones then off_len zeros, restarted by a load.
  assign on_eff   = (cfg_q.on_len == 8'd0) ? 9'd1 : {1'b0, cfg_q.on_len};
  assign period   = on_eff + {1'b0, cfg_q.off_len};
  assign phase_on = (phase_q < on_eff);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      phase_q <= '0;
    end else if (cfg_load || (phase_q >= period - 9'd1)) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + 9'd1;
    end
  end

  psinr_bp_lfsr u_lfsr (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (1'b1),
    .load   (cfg_load),
    .seed   (cfg_bus[BP_CFG_WIDTH-1 -: BP_SEED_W]),
    .state  (lfsr_q)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    bp_ch_state_e state_q;
    logic [7:0]   run_q;
    logic [8:0]   run_inc;
    logic         tready_q;
    logic         evt_q;
    logic         beat;
    logic         stall;
    logic         guard_hit;
    logic         mode_rdy;
    logic         ready_next;

    assign beat      = tvalid_i[i] & tready_q;
    assign stall     = tvalid_i[i] & ~tready_q;
    assign run_inc   = {1'b0, run_q} + 9'd1;
    assign guard_hit = stall && (cfg_q.max_stall != 8'd0) &&
                       (run_inc >= {1'b0, cfg_q.max_stall});

    // NOTE: default assignment first so no path leaves mode_rdy unassigned,
    // which would otherwise infer a latch.
    always_comb begin
      mode_rdy = 1'b0;
      case (cfg_q.mode)
        ALWAYS:   mode_rdy = 1'b1;
        RANDOM:   mode_rdy = (lfsr_q[8*i +: 8] <= cfg_q.thresh);
        PERIODIC: mode_rdy = phase_on;
        HOLD:     mode_rdy = 1'b0;
      endcase
    end

    assign ready_next = cfg_ready & mode_rdy;

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        state_q  <= CH_RUN;
        run_q    <= '0;
        tready_q <= 1'b0;
        evt_q    <= 1'b0;
      end else begin
        evt_q <= 1'b0;
        if (cfg_load) begin
          // A reload beats a same-cycle guard trip: no forced beat, run restarts.
          state_q  <= CH_RUN;
          run_q    <= '0;
          tready_q <= ready_next;
        end else begin
          case (state_q)
            CH_RUN: begin
              if (guard_hit) begin
                state_q  <= CH_FORCE;
                run_q    <= run_inc[7:0];
                tready_q <= 1'b1;
                evt_q    <= 1'b1;
              end else begin
                run_q    <= !stall ? 8'd0 : (run_inc[8] ? 8'hFF : run_inc[7:0]);
                tready_q <= ready_next;
              end
            end
            CH_FORCE: begin
              run_q <= '0;
              if (beat) begin
                state_q  <= CH_RUN;
                tready_q <= ready_next;
              end else begin
                tready_q <= 1'b1;
              end
            end
          endcase
        end
      end
    end

    assign tready_o[i]    = tready_q;
    assign force_evt_o[i] = evt_q;

`ifdef PSINR_BP_STATS_EN
    logic [CNT_W-1:0] beat_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        beat_cnt_q  <= '0;
        stall_cnt_q <= '0;
      end else begin
        if (beat && (beat_cnt_q != '1)) begin
          beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
        if (stall && (stall_cnt_q != '1)) begin
          stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
      end
    end

    assign beat_cnt_o[i*CNT_W +: CNT_W]  = beat_cnt_q;
    assign stall_cnt_o[i*CNT_W +: CNT_W] = stall_cnt_q;
`else
    assign beat_cnt_o[i*CNT_W +: CNT_W]  = '0;
    assign stall_cnt_o[i*CNT_W +: CNT_W] = '0;
`endif
  end

endmodule
